// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA resource schedulers: FSM state encoding and default word width.
package rsa_pkg;

    localparam int DEF_WIDTH = 512;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DELIVER = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  grant,
    output logic            any_req
);
    logic [2*NREQ-1:0] rot_s;

    // Rotate the doubled request vector so bit 0 is the pointer position, then take the lowest hit
    always_comb begin
        rot_s   = {req, req} >> rr_ptr;
        grant   = {IDW{1'b0}};
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && rot_s[k]) begin
                grant   = IDW'((int'(rr_ptr) + k) % NREQ);
                any_req = 1'b1;
            end else begin
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/prime_feed_sched.sv
// Shares one prime_feed between NREQ requesters: round-robin grant, feed handshake with
// timeout, and delivery of the captured p/q/r/s set over a valid/ack handshake.
module prime_feed_sched
    import rsa_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  ack,
    output logic [IDW-1:0]   grant_id,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_p,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_s,
    output logic             feed_next,
    input  logic             feed_ready,
    input  logic [WIDTH-1:0] feed_p,
    input  logic [WIDTH-1:0] feed_q,
    input  logic [WIDTH-1:0] feed_r,
    input  logic [WIDTH-1:0] feed_s,
    output logic             busy,
    output logic             timeout_err,
    input  logic             clear_err
);
    localparam int CW = $clog2(TIMEOUT_CYC);

    state_t          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [CW-1:0]   cnt_r;
    logic [IDW-1:0]  pick_s;
    logic            any_req_s;
    logic            ack_hit_s;
    logic            tmo_hit_s;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_r),
        .grant   (pick_s),
        .any_req (any_req_s)
    );

    // The counter starts at 0 in the first WAIT cycle, so the deadline edge lands TIMEOUT_CYC
    // cycles after the feed_next pulse; a feed_ready on that same cycle still wins.
    always_comb begin
        ack_hit_s = |(ack & (NREQ'(1) << grant_id));
        tmo_hit_s = (cnt_r == CW'(TIMEOUT_CYC - 2));
    end

    // Scheduler FSM with all outputs registered
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {IDW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            grant_id    <= {IDW{1'b0}};
            out_valid   <= 1'b0;
            out_p       <= {WIDTH{1'b0}};
            out_q       <= {WIDTH{1'b0}};
            out_r       <= {WIDTH{1'b0}};
            out_s       <= {WIDTH{1'b0}};
            feed_next   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            feed_next <= 1'b0;
            if (clear_err) begin
                timeout_err <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        state_r <= ST_ARB;
                        busy    <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (any_req_s) begin
                        grant_id  <= pick_s;
                        feed_next <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= {CW{1'b0}};
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (feed_ready) begin
                        out_p     <= feed_p;
                        out_q     <= feed_q;
                        out_r     <= feed_r;
                        out_s     <= feed_s;
                        out_valid <= 1'b1;
                        state_r   <= ST_DELIVER;
                    end else if (tmo_hit_s) begin
                        timeout_err <= 1'b1;
                        state_r     <= ST_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DELIVER: begin
                    if (ack_hit_s) begin
                        out_valid <= 1'b0;
                        rr_ptr_r  <= (grant_id == IDW'(NREQ - 1)) ? {IDW{1'b0}} : grant_id + IDW'(1);
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_feed_sched.sv
// Directed and randomized checks of prime_feed_sched against a round-robin reference model.
module tb_prime_feed_sched;
    localparam int W = 64;
    localparam int N = 4;
    localparam int IW = 2;
    localparam int TMO = 64;

    logic          aclk = 1'b0;
    logic          areset;
    logic [N-1:0]  req, ack;
    logic [IW-1:0] grant_id;
    logic          out_valid, feed_next, feed_ready, busy, timeout_err, clear_err;
    logic [W-1:0]  out_p, out_q, out_r, out_s, feed_p, feed_q, feed_r, feed_s;

    int n_chk = 0;
    int n_fail = 0;
    int fn_cnt = 0;
    int model_ptr = 0;
    logic [W-1:0] m_p = '0, m_q = '0, m_r = '0, m_s = '0;

    prime_feed_sched #(.WIDTH(W), .NREQ(N), .IDW(IW), .TIMEOUT_CYC(TMO)) dut (
        .aclk(aclk), .areset(areset), .req(req), .ack(ack),
        .grant_id(grant_id), .out_valid(out_valid),
        .out_p(out_p), .out_q(out_q), .out_r(out_r), .out_s(out_s),
        .feed_next(feed_next), .feed_ready(feed_ready),
        .feed_p(feed_p), .feed_q(feed_q), .feed_r(feed_r), .feed_s(feed_s),
        .busy(busy), .timeout_err(timeout_err), .clear_err(clear_err)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (feed_next === 1'b1) fn_cnt++;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requester at or after ptr, searching upward modulo N
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_fn(output int lat);
        lat = 0;
        do begin
            @(negedge aclk);
            lat++;
        end while (feed_next !== 1'b1 && lat < 20);
    endtask

    task automatic present_set(input int dly);
        for (int i = 0; i < dly; i++) begin
            @(negedge aclk);
            chk("no_extra_feed_next", feed_next, 1'b0);
        end
        m_p = rnd_word(); m_q = rnd_word(); m_r = rnd_word(); m_s = rnd_word();
        feed_p = m_p; feed_q = m_q; feed_r = m_r; feed_s = m_s;
        feed_ready = 1'b1;
        @(negedge aclk);
        feed_ready = 1'b0;
        feed_p = rnd_word(); feed_q = rnd_word(); feed_r = rnd_word(); feed_s = rnd_word();
        chk("out_valid_rise", out_valid, 1'b1);
        chk("out_p", out_p, m_p);
        chk("out_q", out_q, m_q);
        chk("out_r", out_r, m_r);
        chk("out_s", out_s, m_s);
    endtask

    task automatic run_txn(input logic [N-1:0] rv, input int dly, input bit drop);
        int g, lat;
        g = pick(rv, model_ptr);
        req = rv;
        wait_fn(lat);
        chk("feed_next_latency", lat, 2);
        chk("grant_id", grant_id, g);
        chk("busy_active", busy, 1'b1);
        present_set(dly);
        ack = N'(1) << g;
        if (drop) req = '0;
        @(negedge aclk);
        ack = '0;
        chk("out_valid_fall", out_valid, 1'b0);
        chk("out_p_kept", out_p, m_p);
        model_ptr = (g + 1) % N;
    endtask

    initial begin
        int lat, k, fn0;
        areset = 1'b1; req = '0; ack = '0; feed_ready = 1'b0; clear_err = 1'b0;
        feed_p = '0; feed_q = '0; feed_r = '0; feed_s = '0;
        repeat (2) @(negedge aclk);
        chk("rst_grant", grant_id, 0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_out_p", out_p, 0);
        chk("rst_feed_next", feed_next, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", timeout_err, 1'b0);
        areset = 1'b0;
        @(negedge aclk);

        // Spurious feed_ready while idle
        feed_ready = 1'b1; feed_p = W'(99);
        @(negedge aclk);
        feed_ready = 1'b0;
        @(negedge aclk);
        chk("spur_out_p", out_p, m_p);
        chk("spur_valid", out_valid, 1'b0);
        chk("spur_err", timeout_err, 1'b0);
        chk("spur_busy", busy, 1'b0);

        // Fairness with all requesters held: grants 0,1,2,3,0
        fn0 = fn_cnt;
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 1, (i == 4));
        chk("fair_feed_count", fn_cnt - fn0, 5);

        // Single request with fixed set, then all-request to observe pointer at 2
        req = 4'b0010;
        wait_fn(lat);
        chk("single_grant", grant_id, 1);
        repeat (4) @(negedge aclk);
        feed_p = W'(3); feed_q = W'(5); feed_r = W'(7); feed_s = W'(11); feed_ready = 1'b1;
        @(negedge aclk);
        feed_ready = 1'b0;
        chk("single_valid", out_valid, 1'b1);
        chk("single_p", out_p, 3);
        chk("single_q", out_q, 5);
        chk("single_r", out_r, 7);
        chk("single_s", out_s, 11);
        m_p = W'(3);
        ack = 4'b0010; req = '0;
        @(negedge aclk);
        ack = '0;
        chk("single_release", out_valid, 1'b0);
        model_ptr = 2;
        run_txn(4'b1111, 3, 1'b1);

        // Wrong-bit acks are ignored in DELIVER
        req = 4'b0010;
        wait_fn(lat);
        chk("wack_grant", grant_id, 1);
        present_set(2);
        ack = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("wack_valid_held", out_valid, 1'b1);
            chk("wack_p_held", out_p, m_p);
            chk("wack_s_held", out_s, m_s);
        end
        ack = 4'b0010; req = '0;
        @(negedge aclk);
        ack = '0;
        chk("wack_release", out_valid, 1'b0);
        model_ptr = 2;

        // Timeout, sticky error, retry of the same requester, then clear
        req = 4'b0100;
        wait_fn(lat);
        chk("tmo_grant", grant_id, 2);
        fn0 = fn_cnt;
        k = 0;
        do begin
            @(negedge aclk);
            k++;
        end while (timeout_err !== 1'b1 && k < 100);
        chk("tmo_cycles", k, TMO);
        chk("tmo_single_feed", fn_cnt - fn0, 1);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_valid", out_valid, 1'b0);
        run_txn(4'b0100, 3, 1'b1);
        chk("tmo_sticky", timeout_err, 1'b1);
        clear_err = 1'b1;
        @(negedge aclk);
        clear_err = 1'b0;
        chk("tmo_cleared", timeout_err, 1'b0);

        // Latest acceptable feed_ready is a success
        run_txn(4'b0001, TMO - 1, 1'b1);
        chk("edge_no_err", timeout_err, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 10; i++) begin
            run_txn(N'($urandom_range(1, 15)), $urandom_range(1, 20), $urandom_range(0, 1) == 1);
            req = '0;
            @(negedge aclk);
            @(negedge aclk);
        end
        chk("rand_no_err", timeout_err, 1'b0);

        // Asynchronous reset in the middle of WAIT
        req = 4'b0010;
        wait_fn(lat);
        repeat (2) @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_grant", grant_id, 0);
        chk("arst_out_p", out_p, 0);
        chk("arst_feed_next", feed_next, 1'b0);
        @(negedge aclk);
        areset = 1'b0;
        model_ptr = 0;
        run_txn(4'b1000, 4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
